// File: rtl/instruction_fetcher.sv
// Byte-serial fetch: 4 little-endian bytes per word, 5 cycles/word with full grant; {ins, pc} held on valid/ready.
// Backpressure stops fetch while the word is held; `FETCH_SKID_EN adds a one-word buffer so fetch runs ahead.
module instruction_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        mem_gnt,
    output logic        mem_req,
    output logic [31:0] mem_a,
    input  logic [7:0]  mem_din,
    input  logic        flush_in,
    input  logic [31:0] flush_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc
);

    logic [31:0] r_pc;
    logic [2:0]  r_issue_cnt;
    logic [1:0]  r_recv_cnt;
    logic [23:0] r_word;
    logic        r_inflight;
    logic        r_run;
    logic        r_out_valid;
    logic [31:0] r_out_ins;
    logic [31:0] r_out_pc;

    logic        w_req;
    logic        w_issue;
    logic        w_complete;
    logic        w_hs;
    logic [31:0] w_word;
    logic [2:0]  w_issue_nxt;

    assign w_complete  = r_inflight && (r_recv_cnt == 2'd3);
    assign w_hs        = r_out_valid && out_ready;
    assign w_word      = {mem_din, r_word};
    assign w_issue     = w_req && mem_gnt && rdy_in;
    // issue_cnt is relative to r_pc, so it drops by 4 when the word completes and pc advances
    assign w_issue_nxt = r_issue_cnt + {2'b00, w_issue} - (w_complete ? 3'd4 : 3'd0);

    assign mem_req   = w_req;
    assign mem_a     = r_run ? (r_pc + {29'd0, r_issue_cnt}) : 32'd0;
    assign out_valid = r_out_valid;
    assign out_ins   = r_out_ins;
    assign out_pc    = r_out_pc;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_pc        <= RESET_PC;
            r_issue_cnt <= 3'd0;
            r_recv_cnt  <= 2'd0;
            r_word      <= 24'd0;
            r_inflight  <= 1'b0;
            r_run       <= 1'b0;
        end else if (rdy_in) begin
            r_run <= 1'b1;
            if (flush_in) begin
                // clearing r_inflight drops the byte of any pre-flush address still in flight
                r_pc        <= flush_pc;
                r_issue_cnt <= 3'd0;
                r_recv_cnt  <= 2'd0;
                r_inflight  <= 1'b0;
            end else begin
                r_issue_cnt <= w_issue_nxt;
                r_inflight  <= w_issue;
                if (r_inflight) begin
                    r_recv_cnt <= r_recv_cnt + 2'd1;
                    case (r_recv_cnt)
                        2'd0:    r_word[7:0]   <= mem_din;
                        2'd1:    r_word[15:8]  <= mem_din;
                        2'd2:    r_word[23:16] <= mem_din;
                        default: ;
                    endcase
                end
                if (w_complete) begin
                    r_pc <= r_pc + 32'd4;
                end
            end
        end
    end

`ifdef FETCH_SKID_EN
    logic        r_buf_valid;
    logic [31:0] r_buf_ins;
    logic [31:0] r_buf_pc;
    logic        w_start;
    logic [2:0]  w_occ_nxt;

    // a new word may start only if a slot is free for it after this edge; started words always finish
    assign w_start   = (r_issue_cnt == 3'd0) || ((r_issue_cnt == 3'd4) && w_complete);
    assign w_occ_nxt = {2'b00, r_out_valid} + {2'b00, r_buf_valid} + {2'b00, w_complete} - {2'b00, w_hs};
    assign w_req     = r_run && (((r_issue_cnt != 3'd0) && (r_issue_cnt != 3'd4)) ||
                                 (w_start && (w_occ_nxt < 3'd2)));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_out_valid <= 1'b0;
            r_out_ins   <= 32'd0;
            r_out_pc    <= 32'd0;
            r_buf_valid <= 1'b0;
            r_buf_ins   <= 32'd0;
            r_buf_pc    <= 32'd0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_out_valid <= 1'b0;
                r_buf_valid <= 1'b0;
            end else if (w_hs) begin
                if (r_buf_valid) begin
                    r_out_ins   <= r_buf_ins;
                    r_out_pc    <= r_buf_pc;
                    r_buf_valid <= w_complete;
                    if (w_complete) begin
                        r_buf_ins <= w_word;
                        r_buf_pc  <= r_pc;
                    end
                end else if (w_complete) begin
                    r_out_ins <= w_word;
                    r_out_pc  <= r_pc;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_complete) begin
                if (r_out_valid) begin
                    r_buf_valid <= 1'b1;
                    r_buf_ins   <= w_word;
                    r_buf_pc    <= r_pc;
                end else begin
                    r_out_valid <= 1'b1;
                    r_out_ins   <= w_word;
                    r_out_pc    <= r_pc;
                end
            end
        end
    end
`else
    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    logic [0:0] r_state;

    assign w_req = r_run && (r_state == S_FETCH) && (r_issue_cnt != 3'd4);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= S_FETCH;
            r_out_valid <= 1'b0;
            r_out_ins   <= 32'd0;
            r_out_pc    <= 32'd0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_state     <= S_FETCH;
                r_out_valid <= 1'b0;
            end else if (r_state == S_FETCH) begin
                if (w_complete) begin
                    r_state     <= S_HOLD;
                    r_out_valid <= 1'b1;
                    r_out_ins   <= w_word;
                    r_out_pc    <= r_pc;
                end
            end else if (w_hs) begin
                r_state     <= S_FETCH;
                r_out_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher (default build): cycle-exact vector table, directed flush/reset sequences,
// and a randomized run checked against a transaction-level model of addresses and words.
module tb_instruction_fetcher;

    logic        clk_in    = 1'b0;
    logic        rst_in    = 1'b1;
    logic        rdy_in    = 1'b0;
    logic        mem_gnt   = 1'b0;
    logic        mem_req;
    logic [31:0] mem_a;
    logic [7:0]  mem_din   = 8'd0;
    logic        flush_in  = 1'b0;
    logic [31:0] flush_pc  = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_ins;
    logic [31:0] out_pc;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] W0 = 32'h00A0_0513;

    always #5 clk_in = ~clk_in;

    instruction_fetcher #(.RESET_PC(32'h0000_0000)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .mem_gnt  (mem_gnt),
        .mem_req  (mem_req),
        .mem_a    (mem_a),
        .mem_din  (mem_din),
        .flush_in (flush_in),
        .flush_pc (flush_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ins  (out_ins),
        .out_pc   (out_pc)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'hA0;
            32'd3:   return 8'h00;
            default: return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5C;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    // byte memory with one-cycle read latency, stalled together with the fetcher
    always @(posedge clk_in) begin
        if (rst_in && rdy_in && mem_req && mem_gnt)
            mem_din <= mem_byte(mem_a);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; mem_gnt = 1'b1; out_ready = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic wait_word(input int budget, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < budget) begin
            next_cycle();
            cycles++;
        end
        check("word_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    typedef struct {
        bit          rst;
        bit          gnt;
        bit          rdy_o;
        bit          e_req;
        bit          chk_a;
        logic [31:0] e_a;
        bit          e_vld;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(bit rst, bit gnt, bit rdy_o, bit e_req, bit chk_a, logic [31:0] e_a,
                                 bit e_vld, logic [31:0] e_ins, logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.gnt = gnt; v.rdy_o = rdy_o; v.e_req = e_req; v.chk_a = chk_a; v.e_a = e_a;
        v.e_vld = e_vld; v.e_ins = e_ins; v.e_pc = e_pc;
        return v;
    endfunction

    initial begin
        int          cyc;
        logic [31:0] exp_addr, exp_wpc, prev_ins, prev_pc;
        bit          held, iss, hs;
        int          words;

        // continuous grant: c0..c3 addresses, word visible c5, next address c6
        vecs.push_back(row(1, 1, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(row(0, 1, 1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(row(0, 1, 1, 1, 1, 2, 0, 0, 0));
        vecs.push_back(row(0, 1, 1, 1, 1, 3, 0, 0, 0));
        vecs.push_back(row(0, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row(0, 1, 1, 0, 0, 0, 1, W0, 0));
        vecs.push_back(row(0, 1, 1, 1, 1, 4, 0, W0, 0));
        vecs.push_back(row(0, 1, 1, 1, 1, 5, 0, W0, 0));
        // grant lost for 3 cycles at byte 2
        vecs.push_back(row(1, 1, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(row(0, 1, 1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(row(0, 0, 1, 1, 1, 2, 0, 0, 0));
        vecs.push_back(row(0, 0, 1, 1, 1, 2, 0, 0, 0));
        vecs.push_back(row(0, 0, 1, 1, 1, 2, 0, 0, 0));
        vecs.push_back(row(0, 1, 1, 1, 1, 2, 0, 0, 0));
        vecs.push_back(row(0, 1, 1, 1, 1, 3, 0, 0, 0));
        vecs.push_back(row(0, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row(0, 1, 1, 0, 0, 0, 1, W0, 0));
        vecs.push_back(row(0, 1, 1, 1, 1, 4, 0, W0, 0));
        // queue not ready for 10 cycles: word held, no fetch
        vecs.push_back(row(1, 1, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(row(0, 1, 1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(row(0, 1, 1, 1, 1, 2, 0, 0, 0));
        vecs.push_back(row(0, 1, 1, 1, 1, 3, 0, 0, 0));
        vecs.push_back(row(0, 1, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            vecs.push_back(row(0, 1, 0, 0, 0, 0, 1, W0, 0));
        vecs.push_back(row(0, 1, 1, 0, 0, 0, 1, W0, 0));
        vecs.push_back(row(0, 1, 1, 1, 1, 4, 0, W0, 0));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            else @(negedge clk_in);
            mem_gnt   = vecs[i].gnt;
            out_ready = vecs[i].rdy_o;
            #1;
            check($sformatf("vec%0d_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_req});
            if (vecs[i].chk_a) check($sformatf("vec%0d_a", i), mem_a, vecs[i].e_a);
            check($sformatf("vec%0d_vld", i), {31'd0, out_valid}, {31'd0, vecs[i].e_vld});
            check($sformatf("vec%0d_ins", i), out_ins, vecs[i].e_ins);
            check($sformatf("vec%0d_pc", i), out_pc, vecs[i].e_pc);
        end

        // flush one cycle after byte 1 of pc 8 is issued
        do_reset();
        #1;
        for (int i = 0; i < 14; i++) next_cycle();
        check("flushA_pre_a", mem_a, 32'hA);
        flush_in = 1'b1; flush_pc = 32'h100;
        next_cycle();
        flush_in = 1'b0;
        check("flushA_req", {31'd0, mem_req}, 32'd1);
        check("flushA_a", mem_a, 32'h100);
        check("flushA_vld", {31'd0, out_valid}, 32'd0);
        wait_word(20, cyc);
        check("flushA_lat", cyc, 5);
        check("flushA_pc", out_pc, 32'h100);
        check("flushA_ins", out_ins, exp_word(32'h100));

        // flush together with a handshake
        do_reset();
        #1;
        for (int i = 0; i < 5; i++) next_cycle();
        check("flushB_pre_vld", {31'd0, out_valid}, 32'd1);
        flush_in = 1'b1; flush_pc = 32'h200;
        next_cycle();
        flush_in = 1'b0;
        check("flushB_vld", {31'd0, out_valid}, 32'd0);
        check("flushB_a", mem_a, 32'h200);
        wait_word(20, cyc);
        check("flushB_lat", cyc, 5);
        check("flushB_pc", out_pc, 32'h200);

        // flush together with byte-3 capture, redirect to a wrapping address
        do_reset();
        #1;
        for (int i = 0; i < 4; i++) next_cycle();
        flush_in = 1'b1; flush_pc = 32'hFFFF_FFFE;
        next_cycle();
        flush_in = 1'b0;
        check("flushC_vld", {31'd0, out_valid}, 32'd0);
        check("flushC_a0", mem_a, 32'hFFFF_FFFE);
        next_cycle();
        check("flushC_a1", mem_a, 32'hFFFF_FFFF);
        next_cycle();
        check("flushC_a2", mem_a, 32'h0000_0000);
        next_cycle();
        check("flushC_a3", mem_a, 32'h0000_0001);
        wait_word(20, cyc);
        check("flushC_lat", cyc, 2);
        check("flushC_pc", out_pc, 32'hFFFF_FFFE);
        check("flushC_ins_hi", {16'd0, out_ins[31:16]}, 32'h0000_0513);
        check("flushC_ins", out_ins, exp_word(32'hFFFF_FFFE));

        // global stall mid-word, then reset while stalled
        do_reset();
        #1;
        for (int i = 0; i < 8; i++) next_cycle();
        rdy_in = 1'b0;
        next_cycle();
        check("stall_a", mem_a, 32'd6);
        check("stall_ins", out_ins, W0);
        rst_in = 1'b0;
        #1;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_a", mem_a, 32'd0);
        check("rst_vld", {31'd0, out_valid}, 32'd0);
        check("rst_ins", out_ins, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1; rdy_in = 1'b1;
        next_cycle();
        check("rst_restart_a", mem_a, 32'd0);
        wait_word(20, cyc);
        check("rst_restart_ins", out_ins, W0);
        check("rst_restart_pc", out_pc, 32'd0);

        // randomized traffic against a transaction-level model
        do_reset();
        exp_addr = 32'd0; exp_wpc = 32'd0; held = 1'b0; words = 0;
        prev_ins = 32'd0; prev_pc = 32'd0;
        for (int i = 0; i < 3000; i++) begin
            rdy_in    = ($urandom_range(0, 7) != 0);
            mem_gnt   = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1);
            flush_in  = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0:       flush_pc = 32'hFFFF_FFFE;
                1:       flush_pc = 32'hFFFF_FFFD;
                default: flush_pc = $urandom;
            endcase
            #1;
            if (held) begin
                check("rnd_hold_vld", {31'd0, out_valid}, 32'd1);
                check("rnd_hold_ins", out_ins, prev_ins);
                check("rnd_hold_pc", out_pc, prev_pc);
            end
            iss = rdy_in && mem_req && mem_gnt;
            hs  = rdy_in && out_valid && out_ready;
            if (iss) begin
                check("rnd_addr", mem_a, exp_addr);
                check("rnd_overfetch", {31'd0, (exp_addr - exp_wpc) < 32'd4}, 32'd1);
                exp_addr = exp_addr + 32'd1;
            end
            if (hs) begin
                check("rnd_pc", out_pc, exp_wpc);
                check("rnd_ins", out_ins, exp_word(exp_wpc));
                exp_wpc = exp_wpc + 32'd4;
                words++;
            end
            if (rdy_in && flush_in) begin
                exp_addr = flush_pc;
                exp_wpc  = flush_pc;
            end
            held     = out_valid && !hs && !(rdy_in && flush_in);
            prev_ins = out_ins;
            prev_pc  = out_pc;
            @(negedge clk_in);
        end
        flush_in = 1'b0;
        check("rnd_progress", {31'd0, words >= 50}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
- Fetch stage directly upstream of the instruction queue.
- Reads instructions byte by byte from the shared byte-wide memory port and assembles them little-endian into 32-bit words.
- Presents each word with its PC on a valid/ready interface; the queue pops from it.
- PC is sequential (pc+4); a pipeline flush redirects it to flush_pc.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset.

Ports:
clk_in  in  1  system clock, all state on rising edge
rst_in  in  1  asynchronous active-low reset (0 = reset)
rdy_in  in  1  global ready; 0 freezes every register
mem_gnt  in  1  memory port granted to fetcher this cycle
mem_req  out  1  fetcher requests the memory port
mem_a  out  32  byte read address
mem_din  in  8  read data for address driven previous granted cycle
flush_in  in  1  pipeline flush, redirect fetch
flush_pc  in  32  new PC, valid with flush_in
out_valid  out  1  out_ins/out_pc hold a complete instruction
out_ready  in  1  queue accepts word this cycle
out_ins  out  32  assembled instruction
out_pc  out  32  address of out_ins

Behaviour:
- Reset (rst_in=0, async): pc=RESET_PC, state=FETCH, byte counters=0, mem_req=0, mem_a=0, out_valid=0, out_ins=0, out_pc=0. First request cycle after release.
- Global stall: rdy_in=0 means no register updates, outputs held; the memory is also stalled, so pending data stays coherent.
- Read latency: memory returns data one cycle after a granted address. An address is "issued" in a cycle with mem_req=1 and mem_gnt=1. mem_din is captured the following cycle, even if mem_gnt is then 0.
- State FETCH:
  - mem_req=1; mem_a = pc + issue_cnt (issue_cnt 0..3, increments per issued address).
  - recv_cnt 0..3 counts captured bytes; byte k goes to word[8k+7:8k].
  - Issuing and receiving overlap, so one word takes 5 cycles with continuous grant: addresses in c0..c3, data in c1..c4.
  - When byte 3 is captured: out_ins <= word, out_pc <= pc, out_valid <= 1 (visible c5), pc <= pc+4, go to HOLD.
  - mem_req=0 once issue_cnt reaches 4.
- State HOLD: mem_req=0, out_valid=1, outputs stable. When out_valid & out_ready: out_valid <= 0, counters cleared, go to FETCH; the next address issues the cycle after the handshake.
- Grant loss mid-word: issue pauses and resumes at the same byte offset; no bytes are lost or duplicated.
- Flush (priority over everything, including a same-cycle handshake or byte-3 capture):
  - Next cycle: out_valid=0, pc=flush_pc, counters cleared, state=FETCH, mem_req=1, mem_a=flush_pc.
  - A byte returning the cycle after flush from a pre-flush address is discarded, tracked by a one-bit in-flight flag.
- flush_pc alignment: not checked; fetch proceeds byte-wise from any address.
- Arithmetic: pc and address adders are 32-bit and wrap modulo 2^32; 32'hFFFF_FFFE yields bytes at FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
- out_ins/out_pc change only on capture or reset, never while out_valid=1 without a handshake or flush.

Optional Feature:
- Macro: FETCH_SKID_EN.
- Defined: adds a one-entry word buffer (ins, pc, valid).
  - In HOLD the fetcher continues FETCH of the next word. A completed word goes to the buffer if the output is occupied.
  - On handshake, the buffer moves to the output in the same edge (out_valid stays 1).
  - Fetch stalls (mem_req=0) only when the output and buffer are both full.
  - Flush clears both.
  - Sustained throughput is 1 word/4 cycles with continuous grant.
- Undefined: single output register, behaviour exactly as above (1 word per 5 cycles + handshake).

Test Plan:
- Reset release, RESET_PC=0, mem bytes 0..3 = 13,05,A0,00, mem_gnt=1, out_ready=1: mem_a 0,1,2,3 in c0..c3; out_valid=1 in c5 with out_ins=32'h00A0_0513, out_pc=0; next mem_a=4.
- out_ready=0 for 10 cycles after first word: out_valid stays 1, out_ins/out_pc stable, mem_req=0 (no skid). With FETCH_SKID_EN: word at pc 4 is fetched into the buffer, then mem_req=0.
- mem_gnt=0 during issue of byte 2 for 3 cycles: mem_a holds pc+2; final word is identical to the uninterrupted case and completes 3 cycles later.
- flush_in=1, flush_pc=32'h100, in the cycle after byte 1 of pc 8 is issued: the stray byte is discarded; next cycle mem_a=32'h100; first out_pc=32'h100 with bytes from 100..103; no word from pc 8 is emitted.
- flush_in in the same cycle as out_valid & out_ready: handshake honoured by the queue, but the fetcher still drops out_valid and restarts at flush_pc; flush and byte-3 capture together yield no word.
- rst_in asserted low mid-word (after 2 bytes) and while rdy_in=0: all outputs return to reset values immediately; after release, fetch restarts at RESET_PC.
